// File: rtl/ddr3_pll_ctrl.sv
// DDR3 PLL bring-up/supervision sequencer: holds PLL reset, waits for and qualifies lock, retries with the next loop-filter setting.
// Optional feature macro DDR3_PLL_CTRL_AUTO_RELOCK_EN: on lock loss in LOCKED, restart directly instead of parking in LOST.
module ddr3_pll_ctrl #(
  parameter int RESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT = 200000,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_RETRIES  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       relock_req,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] icpsel,
  output logic [2:0] lpfres,
  output logic [1:0] lpfcap,
  output logic       ready,
  output logic       fail,
  output logic       lock_lost,
  output logic [3:0] attempt,
  output logic [2:0] state
);

  localparam int MAX_RL  = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CNT = (MAX_RL > LOCK_STABLE) ? MAX_RL : LOCK_STABLE;
  localparam int CW      = $clog2(MAX_CNT + 1);

  typedef enum logic [2:0] {
    S_DISABLED  = 3'd0,
    S_RST_HOLD  = 3'd1,
    S_WAIT_LOCK = 3'd2,
    S_STABLE    = 3'd3,
    S_LOCKED    = 3'd4,
    S_LOST      = 3'd5,
    S_FAIL      = 3'd6
  } state_t;

  typedef struct packed {
    logic [5:0] icp;
    logic [2:0] res;
    logic [1:0] cap;
  } pll_cfg_t;

  function automatic pll_cfg_t cfg_entry(input logic [1:0] idx);
    pll_cfg_t c;
    case (idx)
      2'd0:    c = '{icp: 6'h10, res: 3'd2, cap: 2'd0};
      2'd1:    c = '{icp: 6'h18, res: 3'd3, cap: 2'd0};
      2'd2:    c = '{icp: 6'h0C, res: 3'd2, cap: 2'd1};
      default: c = '{icp: 6'h20, res: 3'd4, cap: 2'd1};
    endcase
    return c;
  endfunction

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [1:0]    sync_reg;
  logic [3:0]    attempt_reg;
  pll_cfg_t      cfg_reg;
  logic          pll_reset_reg;
  logic          ready_reg;
  logic          fail_reg;
  logic          lock_lost_reg;

  logic       lock_s;
  logic [3:0] attempt_inc;
  logic       retry_fail;
  logic       retry;

  assign lock_s      = sync_reg[1];
  assign attempt_inc = (attempt_reg == 4'hF) ? 4'hF : attempt_reg + 4'd1;
  assign retry_fail  = (attempt_inc == 4'(MAX_RETRIES));

  // An attempt fails on WAIT_LOCK timeout or on any lock dropout while qualifying.
  always_comb begin
    retry = 1'b0;
    if (state_reg == S_WAIT_LOCK && !lock_s && cnt_reg == CW'(LOCK_TIMEOUT - 1))
      retry = 1'b1;
    if (state_reg == S_STABLE && !lock_s)
      retry = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_DISABLED;
      cnt_reg       <= '0;
      sync_reg      <= 2'b00;
      attempt_reg   <= 4'd0;
      cfg_reg       <= cfg_entry(2'd0);
      pll_reset_reg <= 1'b1;
      ready_reg     <= 1'b0;
      fail_reg      <= 1'b0;
      lock_lost_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], pll_lock};
      if (!en) begin
        state_reg     <= S_DISABLED;
        cnt_reg       <= '0;
        attempt_reg   <= 4'd0;
        pll_reset_reg <= 1'b1;
        ready_reg     <= 1'b0;
        fail_reg      <= 1'b0;
      end else if (relock_req && state_reg != S_DISABLED) begin
        state_reg     <= S_RST_HOLD;
        cnt_reg       <= '0;
        attempt_reg   <= 4'd0;
        cfg_reg       <= cfg_entry(2'd0);
        pll_reset_reg <= 1'b1;
        ready_reg     <= 1'b0;
        fail_reg      <= 1'b0;
        lock_lost_reg <= 1'b0;
      end else if (retry) begin
        cnt_reg       <= '0;
        attempt_reg   <= attempt_inc;
        pll_reset_reg <= 1'b1;
        if (retry_fail) begin
          state_reg <= S_FAIL;
          fail_reg  <= 1'b1;
        end else begin
          state_reg <= S_RST_HOLD;
          cfg_reg   <= cfg_entry(attempt_inc[1:0]);
        end
      end else begin
        case (state_reg)
          S_DISABLED: begin
            state_reg     <= S_RST_HOLD;
            cnt_reg       <= '0;
            cfg_reg       <= cfg_entry(attempt_reg[1:0]);
            pll_reset_reg <= 1'b1;
          end
          S_RST_HOLD: begin
            if (cnt_reg == CW'(RESET_CYCLES - 1)) begin
              state_reg     <= S_WAIT_LOCK;
              cnt_reg       <= '0;
              pll_reset_reg <= 1'b0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          S_WAIT_LOCK: begin
            if (lock_s) begin
              state_reg <= S_STABLE;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          // The lock_s sample that left WAIT_LOCK is the first qualifying cycle.
          S_STABLE: begin
            if (cnt_reg == CW'(LOCK_STABLE - 2)) begin
              state_reg <= S_LOCKED;
              cnt_reg   <= '0;
              ready_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          S_LOCKED: begin
            if (!lock_s) begin
              ready_reg     <= 1'b0;
              lock_lost_reg <= 1'b1;
              cnt_reg       <= '0;
`ifdef DDR3_PLL_CTRL_AUTO_RELOCK_EN
              state_reg     <= S_RST_HOLD;
              pll_reset_reg <= 1'b1;
              cfg_reg       <= cfg_entry(attempt_reg[1:0]);
`else
              state_reg     <= S_LOST;
`endif
            end
          end
          S_LOST, S_FAIL: begin
            cnt_reg <= '0;
          end
          default: begin
            state_reg     <= S_DISABLED;
            cnt_reg       <= '0;
            pll_reset_reg <= 1'b1;
            ready_reg     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pll_reset = pll_reset_reg;
  assign icpsel    = cfg_reg.icp;
  assign lpfres    = cfg_reg.res;
  assign lpfcap    = cfg_reg.cap;
  assign ready     = ready_reg;
  assign fail      = fail_reg;
  assign lock_lost = lock_lost_reg;
  assign attempt   = attempt_reg;
  assign state     = state_reg;

endmodule

// File: tb/tb_ddr3_pll_ctrl.sv
// Bench for ddr3_pll_ctrl: builds an expected per-cycle timeline from the sequencing rules, then replays it against the DUT.
module tb_ddr3_pll_ctrl;

  localparam int RC = 4;
  localparam int LT = 20;
  localparam int LS = 8;
  localparam int MR = 3;

  logic       clk = 1'b0;
  logic       rst_n, en, relock_req, pll_lock;
  logic       pll_reset, ready, fail, lock_lost;
  logic [5:0] icpsel;
  logic [2:0] lpfres;
  logic [1:0] lpfcap;
  logic [3:0] attempt;
  logic [2:0] state;

  always #5 clk = ~clk;

  ddr3_pll_ctrl #(
    .RESET_CYCLES(RC),
    .LOCK_TIMEOUT(LT),
    .LOCK_STABLE (LS),
    .MAX_RETRIES (MR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .relock_req(relock_req),
    .pll_lock  (pll_lock),
    .pll_reset (pll_reset),
    .icpsel    (icpsel),
    .lpfres    (lpfres),
    .lpfcap    (lpfcap),
    .ready     (ready),
    .fail      (fail),
    .lock_lost (lock_lost),
    .attempt   (attempt),
    .state     (state)
  );

  // One record per clock: expected outputs now, and inputs to apply for the next edge.
  typedef struct packed {
    logic       en;
    logic       relock;
    logic       lock;
    logic       rstn;
    logic [2:0] st;
    logic [3:0] att;
    logic [1:0] cfg;
    logic       ll;
  } step_t;

  step_t q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic       d_en, d_relock, d_rstn;
  logic [2:0] m_st;
  int         m_att, m_cfg;
  logic       m_ll;

  function automatic logic [10:0] cfg_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return {6'h10, 3'd2, 2'd0};
      2'd1:    return {6'h18, 3'd3, 2'd0};
      2'd2:    return {6'h0C, 3'd2, 2'd1};
      default: return {6'h20, 3'd4, 2'd1};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic push(input int st, input int n, input logic lock);
    step_t r;
    m_st = 3'(st);
    for (int i = 0; i < n; i++) begin
      r.en = d_en; r.relock = d_relock; r.lock = lock; r.rstn = d_rstn;
      r.st = m_st; r.att = 4'(m_att); r.cfg = 2'(m_cfg); r.ll = m_ll;
      q.push_back(r);
    end
  endtask

  task automatic retry();
    m_att = (m_att == 15) ? 15 : m_att + 1;
    if (m_att != MR) m_cfg = m_att % 4;
  endtask

  // Lock driven d cycles after pll_reset falls reaches lock_s 2 cycles later and is seen 1 cycle after that.
  task automatic wait_and_stable(input int d, input int ns);
    push(1, RC, 1'b0);
    for (int k = 0; k < d + 3; k++) push(2, 1, k >= d);
    push(3, ns, 1'b1);
  endtask

  task automatic attempt_lock(input int d, input int nlocked);
    wait_and_stable(d, LS - 1);
    push(4, nlocked, 1'b1);
  endtask

  task automatic attempt_timeout();
    push(1, RC, 1'b0);
    push(2, LT, 1'b0);
    retry();
  endtask

  task automatic attempt_glitch(input int d, input int h);
    push(1, RC, 1'b0);
    for (int k = 0; k < d + 3 + h; k++) push((k < d + 3) ? 2 : 3, 1, (k >= d) && (k < d + h));
    retry();
  endtask

  task automatic relock();
    d_relock = 1'b1;
    push(m_st, 1, 1'b0);
    d_relock = 1'b0;
    m_att = 0; m_cfg = 0; m_ll = 1'b0;
  endtask

  // en low wins over a simultaneous relock_req; lock_lost and settings are kept.
  task automatic drop_en();
    d_en = 1'b0; d_relock = 1'b1;
    push(m_st, 1, 1'b0);
    m_att = 0;
    push(0, 1, 1'b0);
    d_relock = 1'b0;
    push(0, 1, 1'b0);
    d_en = 1'b1;
    push(0, 1, 1'b0);
  endtask

  task automatic rst_pulse();
    d_rstn = 1'b0;
    push(m_st, 1, 1'b0);
    m_att = 0; m_cfg = 0; m_ll = 1'b0;
    d_rstn = 1'b1;
    push(0, 1, 1'b0);
  endtask

  initial begin
    int  kind;
    logic done;

    d_en = 1'b1; d_relock = 1'b0; d_rstn = 1'b1;
    m_st = 3'd0; m_att = 0; m_cfg = 0; m_ll = 1'b0;

    // Reset dominates even with en high.
    rst_n = 1'b0; en = 1'b1; relock_req = 1'b0; pll_lock = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pll_reset", 32'(pll_reset), 32'd1);
    chk("rst_cfg", 32'({icpsel, lpfres, lpfcap}), 32'(cfg_of(2'd0)));
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_fail", 32'(fail), 32'd0);
    chk("rst_lock_lost", 32'(lock_lost), 32'd0);
    chk("rst_attempt", 32'(attempt), 32'd0);
    en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);

    // Clean lock 3 cycles after pll_reset falls.
    push(0, 1, 1'b0);
    attempt_lock(3, 4);

    // Lock loss while LOCKED: visible 3 cycles after pll_lock drops.
    push(4, 3, 1'b0);
    m_ll = 1'b1;
`ifdef DDR3_PLL_CTRL_AUTO_RELOCK_EN
    attempt_lock($urandom_range(0, LT - 3), 2);
`else
    push(5, 2, 1'b0);
`endif
    drop_en();

    // en dropped in WAIT_LOCK; lock_lost stays sticky until relock.
    push(1, RC, 1'b0);
    push(2, 6, 1'b0);
    drop_en();
    attempt_lock($urandom_range(0, LT - 3), 2);
    relock();

    // Timeout, then lock at the last usable cycle on attempt 1.
    attempt_timeout();
    attempt_lock(LT - 3, 2);
    relock();

    // Glitch: 5 cycles of lock then a dropout during qualification.
    attempt_glitch($urandom_range(0, 10), 5);
    attempt_lock($urandom_range(0, LT - 3), 2);
    relock();

    // Exhaustion, then recovery via relock_req.
    attempt_timeout();
    attempt_timeout();
    attempt_timeout();
    push(6, 3, 1'b0);
    relock();

    // rst_n pulsed mid-qualification.
    wait_and_stable($urandom_range(0, LT - 3), 3);
    rst_pulse();
    attempt_lock($urandom_range(0, LT - 3), 2);

    // Randomised attempt sequences.
    for (int s = 0; s < 6; s++) begin
      relock();
      done = 1'b0;
      while (!done) begin
        kind = int'($urandom_range(0, 2));
        if (kind == 0) begin
          attempt_timeout();
        end else if (kind == 1) begin
          attempt_glitch($urandom_range(0, 10), $urandom_range(1, LS - 1));
        end else begin
          attempt_lock($urandom_range(0, LT - 3), 2);
          done = 1'b1;
        end
        if (!done && m_att == MR) begin
          push(6, 2, 1'b0);
          done = 1'b1;
        end
      end
    end

    foreach (q[i]) begin
      chk("state", 32'(state), 32'(q[i].st));
      chk("pll_reset", 32'(pll_reset), (q[i].st == 3'd0 || q[i].st == 3'd1 || q[i].st == 3'd6) ? 32'd1 : 32'd0);
      chk("ready", 32'(ready), (q[i].st == 3'd4) ? 32'd1 : 32'd0);
      chk("fail", 32'(fail), (q[i].st == 3'd6) ? 32'd1 : 32'd0);
      chk("lock_lost", 32'(lock_lost), 32'(q[i].ll));
      chk("attempt", 32'(attempt), 32'(q[i].att));
      chk("cfg", 32'({icpsel, lpfres, lpfcap}), 32'(cfg_of(q[i].cfg)));
      rst_n      = q[i].rstn;
      en         = q[i].en;
      relock_req = q[i].relock;
      pll_lock   = q[i].lock;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddr3_pll_ctrl.md
Name: ddr3_pll_ctrl

Overview:
Bring-up and supervision sequencer for the DDR3 PLL. Runs on the PLL's free-running 100 MHz reference clock. Drives PLL reset and the dynamic charge-pump/loop-filter selects, then waits for lock and qualifies it as stable before raising `ready` to the DDR3 PHY reset tree. On timeout or unstable lock it retries with the next loop-filter setting; after too many attempts it declares failure.

Parameters:
- RESET_CYCLES, 16: cycles `pll_reset` is held high per attempt (>=2).
- LOCK_TIMEOUT, 200000: max cycles in WAIT_LOCK before the attempt fails.
- LOCK_STABLE, 1024: consecutive synced-lock cycles required before `ready`.
- MAX_RETRIES, 8: failed attempts allowed before FAIL (1..15).

Ports:
- clk  in  1  free-running 100 MHz reference clock (same net as PLL clkin)
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  level; 0 forces DISABLED
- relock_req  in  1  single-cycle pulse; restart sequence from attempt 0
- pll_lock  in  1  raw PLL lock, asynchronous; 2-FF synchronised internally to lock_s
- pll_reset  out  1  PLL reset, active-high
- icpsel  out  6  PLL charge-pump select
- lpfres  out  3  PLL loop-filter resistor select
- lpfcap  out  2  PLL loop-filter capacitor select
- ready  out  1  PLL locked and qualified
- fail  out  1  retries exhausted (sticky until relock_req/en low/rst_n)
- lock_lost  out  1  sticky: lock dropped while LOCKED
- attempt  out  4  failed attempts in current sequence
- state  out  3  DISABLED=0, RST_HOLD=1, WAIT_LOCK=2, STABLE=3, LOCKED=4, LOST=5, FAIL=6

Behaviour:
- All outputs registered. Reset values:
  - state=DISABLED, pll_reset=1
  - icpsel/lpfres/lpfcap = table entry 0
  - ready=0, fail=0, lock_lost=0, attempt=0
  - sync flops=0
- Settings table, indexed by attempt[1:0]:
  - 0: icp 6'h10, res 3'd2, cap 2'd0
  - 1: icp 6'h18, res 3'd3, cap 2'd0
  - 2: icp 6'h0C, res 3'd2, cap 2'd1
  - 3: icp 6'h20, res 3'd4, cap 2'd1
- Settings update only on the cycle of entry into RST_HOLD and are held constant otherwise.
- pll_reset=1 in DISABLED, RST_HOLD, FAIL; 0 elsewhere.
- DISABLED: if en=1, go to RST_HOLD next cycle.
- RST_HOLD: exactly RESET_CYCLES cycles, then WAIT_LOCK; cycle counter cleared on every state entry.
- WAIT_LOCK:
  - lock_s=1 -> STABLE.
  - LOCK_TIMEOUT cycles elapsed with lock_s=0 -> retry.
- STABLE:
  - LOCK_STABLE consecutive lock_s=1 cycles -> LOCKED, with ready=1 in the same cycle state reads 4.
  - Any lock_s=0 -> retry.
- Retry:
  - attempt+1 (saturating at 15).
  - If the new attempt == MAX_RETRIES -> FAIL (fail=1); else RST_HOLD with table entry attempt[1:0].
- LOCKED: lock_s=0 -> ready=0 and lock_lost=1 on the next edge, state -> LOST (without the optional feature).
- LOST, FAIL: hold until relock_req or en=0.
- relock_req:
  - Valid in any state except DISABLED.
  - Next cycle: RST_HOLD, attempt=0, fail=0, lock_lost=0, settings entry 0, ready=0.
  - Ignored while en=0.
- en=0 in any state: next cycle DISABLED, pll_reset=1, ready=0, attempt=0, fail=0; lock_lost retained.
- Priority: rst_n > en=0 > relock_req > state transitions.
- Counter width: $clog2 of max(RESET_CYCLES, LOCK_TIMEOUT, LOCK_STABLE)+1; no wrap possible.
- rst_n low mid-sequence: all outputs return to reset values on that edge.

Optional Feature:
- Macro: DDR3_PLL_CTRL_AUTO_RELOCK_EN.
- Defined:
  - LOCKED with lock_s=0 -> ready=0 and lock_lost=1 next edge, state -> RST_HOLD directly (LOST unused).
  - attempt is unchanged, so the current settings are retained.
  - The counts against MAX_RETRIES still apply on subsequent failures.
- Undefined: behaviour as above (park in LOST).

Test Plan:
Bench parameters for all scenarios: RESET_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRIES=3.
1. Clean lock: en=1, pll_lock rises 3 cycles after pll_reset falls -> pll_reset high 4 cycles; ready=1 exactly 2 (sync) + 8 cycles after lock rise; icpsel=6'h10, attempt=0.
2. Timeout then lock: no lock on attempt 0 -> after 20 WAIT_LOCK cycles, pll_reset re-asserts for 4 cycles, icpsel=6'h18, lpfres=3; lock on attempt 1 -> ready=1, attempt=1.
3. Lock glitch: lock high 5 cycles then low 1 cycle during STABLE -> retry, attempt=1, ready stays 0.
4. Exhaustion: lock tied 0 -> after 3 timeouts state=6, fail=1, pll_reset=1; relock_req pulse -> attempt=0, fail=0, state=1 next cycle.
5. Lock loss: in LOCKED drop pll_lock -> ready=0 3 cycles later (2 sync + 1); state=5, lock_lost=1. With AUTO_RELOCK_EN: state=1 instead, then relock completes.
6. en dropped in WAIT_LOCK and rst_n pulsed mid-STABLE -> state=0, pll_reset=1, settings entry 0, ready=0 on the following edge.
